// File: rtl/el2_dccm_bank_responder.sv
// RAM-side responder for the exported DCCM bank interface: per-bank storage with
// registered read data/ECC, post-reset zero fill, and a one-shot single-bit error injector.
module el2_dccm_bank_responder #(
    parameter int DCCM_NUM_BANKS  = 4,
    parameter int DCCM_BANK_BITS  = 2,
    parameter int DCCM_INDEX_BITS = 11,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7
) (
    input  logic                                        clk,
    input  logic                                        rst_l,
    input  logic [DCCM_NUM_BANKS-1:0]                   dccm_clken,
    input  logic [DCCM_NUM_BANKS-1:0]                   dccm_wren_bank,
    input  logic [DCCM_NUM_BANKS*DCCM_INDEX_BITS-1:0]   dccm_addr_bank,
    input  logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0]   dccm_wr_data_bank,
    input  logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]    dccm_wr_ecc_bank,
    output logic [DCCM_NUM_BANKS*DCCM_DATA_WIDTH-1:0]   dccm_bank_dout,
    output logic [DCCM_NUM_BANKS*DCCM_ECC_WIDTH-1:0]    dccm_bank_ecc,
    output logic                                        init_done,
    input  logic                                        inj_en,
    input  logic [DCCM_BANK_BITS-1:0]                   inj_bank,
    input  logic [5:0]                                  inj_bit,
    output logic                                        inj_pending
);
    localparam int NB    = DCCM_NUM_BANKS;
    localparam int IW    = DCCM_INDEX_BITS;
    localparam int DW    = DCCM_DATA_WIDTH;
    localparam int EW    = DCCM_ECC_WIDTH;
    localparam int WW    = DW + EW;
    localparam int DEPTH = 2 ** IW;

    localparam logic [1:0]    ST_INIT  = 2'b01;
    localparam logic [1:0]    ST_READY = 2'b10;
    localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [WW-1:0] WORD_ZERO = {WW{1'b0}};

    // One-hot flip mask over {ecc,data}; selectors past the word width give no flip.
    function automatic logic [WW-1:0] flip_mask(input logic [5:0] bit_sel);
        logic [WW-1:0] m;
        m = {WW{1'b0}};
        for (int j = 0; j < WW; j++) begin
            m[j] = (bit_sel == 6'(j));
        end
        return m;
    endfunction

    logic [1:0]                state_r;
    logic [1:0]                state_nxt_s;
    logic [IW-1:0]             init_idx_r;
    logic                      init_done_r;
    logic                      init_mode_s;
    logic                      ready_s;
    logic                      inj_pending_r;
    logic [DCCM_BANK_BITS-1:0] inj_bank_r;
    logic [5:0]                inj_bit_r;
    logic [NB-1:0]             bank_rd_s;
    logic [NB-1:0]             bank_wr_s;
    logic [NB-1:0]             inj_hit_s;
    logic                      inj_consume_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: leave INIT once the last index has been cleared
    always_comb begin
        state_nxt_s = ST_INIT;
        case (state_r)
            ST_INIT: begin
                if (init_idx_r == IDX_LAST) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_READY: state_nxt_s = ST_READY;
            default:  state_nxt_s = ST_INIT;
        endcase
    end

    // FSM output decode; an illegal encoding behaves as INIT (bus blocked)
    always_comb begin
        init_mode_s = 1'b0;
        ready_s     = 1'b0;
        case (state_r)
            ST_INIT:  init_mode_s = 1'b1;
            ST_READY: ready_s     = 1'b1;
            default:  init_mode_s = 1'b1;
        endcase
    end

    // Init index counter and registered done flag
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            init_idx_r  <= IDX_ZERO;
            init_done_r <= 1'b0;
        end else begin
            if (init_mode_s) begin
                init_idx_r <= init_idx_r + IDX_ONE;
            end else begin
                init_idx_r <= init_idx_r;
            end
            init_done_r <= (state_nxt_s == ST_READY);
        end
    end

    // Per-bank access qualification and injector hit detection
    always_comb begin
        bank_rd_s = {NB{1'b0}};
        bank_wr_s = {NB{1'b0}};
        inj_hit_s = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            bank_rd_s[i] = ready_s & dccm_clken[i] & ~dccm_wren_bank[i];
            bank_wr_s[i] = init_mode_s | (ready_s & dccm_clken[i] & dccm_wren_bank[i]);
            inj_hit_s[i] = inj_pending_r & bank_rd_s[i] & (inj_bank_r == DCCM_BANK_BITS'(i));
        end
        inj_consume_s = |inj_hit_s;
    end

    // Injector arm/consume; a fresh arm overrides a consume in the same cycle
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            inj_pending_r <= 1'b0;
            inj_bank_r    <= {DCCM_BANK_BITS{1'b0}};
            inj_bit_r     <= 6'd0;
        end else if (inj_en) begin
            inj_pending_r <= 1'b1;
            inj_bank_r    <= inj_bank;
            inj_bit_r     <= inj_bit;
        end else begin
            inj_pending_r <= inj_pending_r & ~inj_consume_s;
            inj_bank_r    <= inj_bank_r;
            inj_bit_r     <= inj_bit_r;
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_bank
        logic [WW-1:0] mem_r [DEPTH];
        logic [IW-1:0] addr_s;
        logic [WW-1:0] wdata_s;
        logic [WW-1:0] rword_s;
        logic [DW-1:0] dout_r;
        logic [EW-1:0] ecc_r;

        // INIT takes over the address and forces the all-zero codeword
        always_comb begin
            if (init_mode_s) begin
                addr_s  = init_idx_r;
                wdata_s = WORD_ZERO;
            end else begin
                addr_s  = dccm_addr_bank[g*IW +: IW];
                wdata_s = {dccm_wr_ecc_bank[g*EW +: EW], dccm_wr_data_bank[g*DW +: DW]};
            end
        end

        // Array write; contents intentionally survive reset
        always_ff @(posedge clk) begin
            if (bank_wr_s[g]) begin
                mem_r[addr_s] <= wdata_s;
            end
        end

        // Read word, with the injected bit inverted only on the output path
        always_comb begin
            if (inj_hit_s[g]) begin
                rword_s = mem_r[addr_s] ^ flip_mask(inj_bit_r);
            end else begin
                rword_s = mem_r[addr_s];
            end
        end

        // Registered read data/ECC, held when the bank is not reading
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                dout_r <= {DW{1'b0}};
                ecc_r  <= {EW{1'b0}};
            end else if (bank_rd_s[g]) begin
                dout_r <= rword_s[DW-1:0];
                ecc_r  <= rword_s[WW-1:DW];
            end else begin
                dout_r <= dout_r;
                ecc_r  <= ecc_r;
            end
        end

        assign dccm_bank_dout[g*DW +: DW] = dout_r;
        assign dccm_bank_ecc[g*EW +: EW]  = ecc_r;
    end

    assign init_done   = init_done_r;
    assign inj_pending = inj_pending_r;

endmodule

// File: tb/tb_el2_dccm_bank_responder.sv
// Scoreboard bench for el2_dccm_bank_responder: a behavioural bank/injector model pushes
// expected outputs per cycle and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_el2_dccm_bank_responder;
    localparam int NB = 4, BB = 2, IW = 11, DW = 32, EW = 7;
    localparam int WW = DW + EW;
    localparam int DEPTH = 2 ** IW;

    logic             clk = 1'b0;
    logic             rst_l;
    logic [NB-1:0]    clken, wren;
    logic [IW-1:0]    addr  [NB];
    logic [DW-1:0]    wdata [NB];
    logic [EW-1:0]    wecc  [NB];
    logic [NB*IW-1:0] addr_flat;
    logic [NB*DW-1:0] wd_flat;
    logic [NB*EW-1:0] we_flat;
    logic [NB*DW-1:0] dout;
    logic [NB*EW-1:0] ecc;
    logic             init_done, inj_en, inj_pending;
    logic [BB-1:0]    inj_bank;
    logic [5:0]       inj_bit;

    always #5 clk = ~clk;

    always_comb begin
        addr_flat = '0;
        wd_flat   = '0;
        we_flat   = '0;
        for (int i = 0; i < NB; i++) begin
            addr_flat[i*IW +: IW] = addr[i];
            wd_flat[i*DW +: DW]   = wdata[i];
            we_flat[i*EW +: EW]   = wecc[i];
        end
    end

    el2_dccm_bank_responder #(
        .DCCM_NUM_BANKS(NB), .DCCM_BANK_BITS(BB), .DCCM_INDEX_BITS(IW),
        .DCCM_DATA_WIDTH(DW), .DCCM_ECC_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_l(rst_l), .dccm_clken(clken), .dccm_wren_bank(wren),
        .dccm_addr_bank(addr_flat), .dccm_wr_data_bank(wd_flat), .dccm_wr_ecc_bank(we_flat),
        .dccm_bank_dout(dout), .dccm_bank_ecc(ecc), .init_done(init_done),
        .inj_en(inj_en), .inj_bank(inj_bank), .inj_bit(inj_bit), .inj_pending(inj_pending)
    );

    // Reference model: bank contents, output registers and injector state
    logic [WW-1:0] m_mem [NB][DEPTH];
    logic [WW-1:0] m_out [NB];
    bit m_ready;
    int m_cnt;
    bit m_pend;
    int m_bank, m_bit;

    typedef struct {
        int               due;
        logic [NB*DW-1:0] d;
        logic [NB*EW-1:0] e;
        logic             done;
        logic             pend;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Apply the current inputs to the model for the coming edge, queue the result, clock.
    task automatic step();
        exp_t x;
        bit used;
        logic [WW-1:0] w;
        used = 1'b0;
        if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int b = 0; b < NB; b++)
                    for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (clken[b]) begin
                    if (wren[b]) begin
                        m_mem[b][addr[b]] = {wecc[b], wdata[b]};
                    end else begin
                        w = m_mem[b][addr[b]];
                        if (m_pend && m_bank == b) begin
                            used = 1'b1;
                            if (m_bit < WW) w[m_bit] = ~w[m_bit];
                        end
                        m_out[b] = w;
                    end
                end
            end
        end
        if (inj_en) begin
            m_pend = 1'b1;
            m_bank = int'(inj_bank);
            m_bit  = int'(inj_bit);
        end else if (used) begin
            m_pend = 1'b0;
        end
        x.due = cyc + 1;
        x.d = '0;
        x.e = '0;
        for (int b = 0; b < NB; b++) begin
            x.d[b*DW +: DW] = m_out[b][DW-1:0];
            x.e[b*EW +: EW] = m_out[b][WW-1:DW];
        end
        x.done = m_ready;
        x.pend = m_pend;
        sb.push_back(x);
        @(posedge clk);
        #1;
        inj_en = 1'b0;
    endtask

    task automatic rand_bus(input int amax);
        for (int b = 0; b < NB; b++) begin
            clken[b] = 1'($urandom_range(0, 1));
            wren[b]  = 1'($urandom_range(0, 1));
            addr[b]  = IW'($urandom_range(0, amax));
            wdata[b] = $urandom;
            wecc[b]  = EW'($urandom);
        end
    endtask

    task automatic idle();
        rand_bus(DEPTH - 1);
        clken = '0;
        step();
    endtask

    task automatic rd(input int b, input logic [IW-1:0] a);
        rand_bus(DEPTH - 1);
        clken = '0;
        clken[b] = 1'b1;
        wren[b] = 1'b0;
        addr[b] = a;
        step();
    endtask

    task automatic wr(input int b, input logic [IW-1:0] a, input logic [DW-1:0] d, input logic [EW-1:0] e);
        rand_bus(DEPTH - 1);
        clken = '0;
        clken[b] = 1'b1;
        wren[b] = 1'b1;
        addr[b] = a;
        wdata[b] = d;
        wecc[b] = e;
        step();
    endtask

    task automatic arm(input int b, input int bitn);
        inj_en = 1'b1;
        inj_bank = BB'(b);
        inj_bit = 6'(bitn);
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_cnt = 0;
        m_pend = 1'b0;
        for (int b = 0; b < NB; b++) m_out[b] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_l = 1'b0;
        #1;
        chk("rst_dout", 128'(dout), 128'(0));
        chk("rst_ecc", 128'(ecc), 128'(0));
        chk("rst_init_done", 128'(init_done), 128'(0));
        chk("rst_inj_pending", 128'(inj_pending), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    // Monitor: compare every expectation that falls due on this cycle
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            if (x.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL late_entry cyc=%0d got=none want=due%0d", cyc, x.due);
            end else begin
                chk("dout", 128'(dout), 128'(x.d));
                chk("ecc", 128'(ecc), 128'(x.e));
                chk("init_done", 128'(init_done), 128'(x.done));
                chk("inj_pending", 128'(inj_pending), 128'(x.pend));
            end
        end
    end

    initial begin
        rst_l = 1'b0;
        inj_en = 1'b0;
        inj_bank = '0;
        inj_bit = '0;
        rand_bus(DEPTH - 1);
        clken = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 128'(dout), 128'(0));
        chk("rst_init_done", 128'(init_done), 128'(0));
        chk("rst_inj_pending", 128'(inj_pending), 128'(0));
        rst_l = 1'b1;

        // Initialisation, with ignored bus traffic in a window
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= 100 && i < 200) begin
                rand_bus(DEPTH - 1);
                step();
            end else begin
                idle();
            end
        end

        rd(2, 11'h7FF);
        wr(1, 11'h123, 32'hDEADBEEF, 7'h55);
        rd(1, 11'h123);
        idle();

        // Unaligned pair: bank3 idx5 and bank0 idx6
        rand_bus(DEPTH - 1);
        clken = 4'b1001;
        wren = 4'b1001;
        addr[3] = 11'd5; wdata[3] = 32'h11111111;
        addr[0] = 11'd6; wdata[0] = 32'h22222222;
        step();
        rand_bus(DEPTH - 1);
        clken = 4'b1001;
        wren = 4'b0000;
        addr[3] = 11'd5;
        addr[0] = 11'd6;
        step();
        repeat (3) idle();

        // Injector
        arm(1, 0);
        idle();
        rd(0, 11'd6);
        rd(1, 11'h123);
        rd(1, 11'h123);
        arm(1, 35);
        rd(1, 11'h123);
        arm(3, 50);
        rd(3, 11'd5);
        idle();

        // Arm in the same cycle as a consuming read
        arm(1, 1);
        idle();
        rand_bus(DEPTH - 1);
        clken = 4'b0010;
        wren[1] = 1'b0;
        addr[1] = 11'h123;
        arm(2, 4);
        step();
        rd(2, 11'd0);
        idle();

        // Random traffic over a small index range to exercise read-after-write
        for (int i = 0; i < 400; i++) begin
            rand_bus(7);
            if ($urandom_range(0, 9) == 0) arm(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 45)));
            step();
        end

        // Reset mid-initialisation, then arm during INIT
        do_reset();
        for (int i = 0; i < 1000; i++) idle();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 20) arm(0, 38);
            idle();
        end
        rd(1, 11'h123);
        rd(0, 11'd6);
        rd(3, 11'd5);
        repeat (3) idle();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
